// File: rtl/scr1_dmi_scan_responder.sv
// SysCLK-side DMI scan responder: owns the 41-bit DMI scan register fed by
// synchronized TAPC strobes and turns updates into Debug Module requests.
// Optional DTMCS register is compiled in with `define SCR1_DMI_DTMCS_EN.
`ifndef SCR1_DBG_DMI_CH_ID_WIDTH
`define SCR1_DBG_DMI_CH_ID_WIDTH 2
`endif

module scr1_dmi_scan_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter logic [`SCR1_DBG_DMI_CH_ID_WIDTH-1:0] DMI_CH_ID   = `SCR1_DBG_DMI_CH_ID_WIDTH'(1),
    parameter logic [`SCR1_DBG_DMI_CH_ID_WIDTH-1:0] DTMCS_CH_ID = `SCR1_DBG_DMI_CH_ID_WIDTH'(0)
) (
    input  logic                                 clk,
    input  logic                                 tapc_trst_n,
    input  logic                                 ch_sel,
    input  logic [`SCR1_DBG_DMI_CH_ID_WIDTH-1:0] ch_id,
    input  logic                                 ch_capture,
    input  logic                                 ch_shift,
    input  logic                                 ch_update,
    input  logic                                 ch_tdi,
    output logic                                 ch_tdo,
    output logic                                 dmi_req,
    output logic                                 dmi_wr,
    output logic [ADDR_W-1:0]                    dmi_addr,
    output logic [DATA_W-1:0]                    dmi_wdata,
    input  logic                                 dmi_resp,
    input  logic [DATA_W-1:0]                    dmi_rdata
);

    localparam int SCAN_W = ADDR_W + DATA_W + 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              state;
    logic [SCAN_W-1:0]   scan_q;
    logic [SCAN_W-1:0]   scan_nxt;
    logic [DATA_W-1:0]   rdata_q;
    logic                sticky_err;
    logic                dmi_hit;
    logic                dmi_upd;
    logic                busy;
    logic [1:0]          status;
    logic [1:0]          upd_op;
    logic                issue;
    logic                busy_err;
    logic                err_clr;
    logic                hard_rst;

    assign dmi_hit  = ch_sel && (ch_id == DMI_CH_ID);
    assign dmi_upd  = dmi_hit && ch_update;
    assign busy     = (state != ST_IDLE);
    // Busy and sticky error both report as status 3; the DM never reports failure itself.
    assign status   = (busy || sticky_err) ? 2'b11 : 2'b00;
    assign upd_op   = scan_q[1:0];
    // Busy is judged on the pre-edge state, so an update coinciding with dmi_resp still errors.
    assign issue    = dmi_upd && !busy && ((upd_op == 2'd1) || (upd_op == 2'd2));
    assign busy_err = dmi_upd && busy && (upd_op != 2'd0);

    // Next DMI scan register value: update blocks capture, capture blocks shift
    always_comb begin
        scan_nxt = scan_q;
        if (dmi_hit && !ch_update) begin
            if (ch_capture) begin
                scan_nxt = {dmi_addr, rdata_q, status};
            end else if (ch_shift) begin
                scan_nxt = {ch_tdi, scan_q[SCAN_W-1:1]};
            end
        end
    end

    // DMI scan register storage
    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_nxt;
        end
    end

`ifdef SCR1_DMI_DTMCS_EN
    logic [31:0] dtmcs_q;
    logic [31:0] dtmcs_nxt;
    logic        dtmcs_hit;
    logic        dtmcs_upd;

    assign dtmcs_hit = ch_sel && (ch_id == DTMCS_CH_ID);
    assign dtmcs_upd = dtmcs_hit && ch_update;
    // dmihardreset implies dmireset as well as abandoning the transaction.
    assign err_clr   = dtmcs_upd && (dtmcs_q[16] || dtmcs_q[17]);
    assign hard_rst  = dtmcs_upd && dtmcs_q[17];

    // Next DTMCS value: fixed version/abits, dmistat mirrors the sticky error
    always_comb begin
        dtmcs_nxt = dtmcs_q;
        if (dtmcs_hit && !ch_update) begin
            if (ch_capture) begin
                dtmcs_nxt = {17'd0, 3'd0, (sticky_err ? 2'b11 : 2'b00), 6'(ADDR_W), 4'd1};
            end else if (ch_shift) begin
                dtmcs_nxt = {ch_tdi, dtmcs_q[31:1]};
            end
        end
    end

    // DTMCS register storage
    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            dtmcs_q <= '0;
        end else begin
            dtmcs_q <= dtmcs_nxt;
        end
    end

    // TDO follows bit 0 of whichever register the chain id addresses
    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            ch_tdo <= 1'b0;
        end else begin
            ch_tdo <= (ch_id == DTMCS_CH_ID) ? dtmcs_nxt[0] : scan_nxt[0];
        end
    end
`else
    logic unused_dtmcs_id;

    assign unused_dtmcs_id = (DTMCS_CH_ID == DMI_CH_ID);
    assign err_clr         = 1'b0;
    assign hard_rst        = 1'b0;

    // TDO mirrors bit 0 of the DMI scan register
    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            ch_tdo <= 1'b0;
        end else begin
            ch_tdo <= scan_nxt[0];
        end
    end
`endif

    // Sticky busy error: only a busy update sets it, only dmireset or reset clears it
    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            sticky_err <= 1'b0;
        end else if (busy_err) begin
            sticky_err <= 1'b1;
        end else if (err_clr) begin
            sticky_err <= 1'b0;
        end
    end

    // Request FSM with registered DM-side outputs
    always_ff @(posedge clk or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            state     <= ST_IDLE;
            dmi_req   <= 1'b0;
            dmi_wr    <= 1'b0;
            dmi_addr  <= '0;
            dmi_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state    <= ST_REQ;
                        dmi_req  <= 1'b1;
                        dmi_wr   <= (upd_op == 2'd2);
                        dmi_addr <= scan_q[SCAN_W-1 -: ADDR_W];
                        if (upd_op == 2'd2) begin
                            dmi_wdata <= scan_q[DATA_W+1:2];
                        end
                    end
                end
                ST_REQ: begin
                    if (dmi_resp) begin
                        state   <= ST_IDLE;
                        dmi_req <= 1'b0;
                        if (!dmi_wr) begin
                            rdata_q <= dmi_rdata;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    dmi_req <= 1'b0;
                end
            endcase
            if (hard_rst) begin
                state   <= ST_IDLE;
                dmi_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scr1_dmi_scan_responder.sv
// Bench for scr1_dmi_scan_responder: transaction table, hand-written corner
// sequences and a randomized phase, all checked against a behavioural model.
`ifndef SCR1_DBG_DMI_CH_ID_WIDTH
`define SCR1_DBG_DMI_CH_ID_WIDTH 2
`endif

module tb_scr1_dmi_scan_responder;

    localparam int CHW = `SCR1_DBG_DMI_CH_ID_WIDTH;
    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int SW  = AW + DW + 2;

    logic           clk;
    logic           tapc_trst_n;
    logic           ch_sel;
    logic [CHW-1:0] ch_id;
    logic           ch_capture;
    logic           ch_shift;
    logic           ch_update;
    logic           ch_tdi;
    logic           ch_tdo;
    logic           dmi_req;
    logic           dmi_wr;
    logic [AW-1:0]  dmi_addr;
    logic [DW-1:0]  dmi_wdata;
    logic           dmi_resp;
    logic [DW-1:0]  dmi_rdata;

    scr1_dmi_scan_responder dut (
        .clk         (clk),
        .tapc_trst_n (tapc_trst_n),
        .ch_sel      (ch_sel),
        .ch_id       (ch_id),
        .ch_capture  (ch_capture),
        .ch_shift    (ch_shift),
        .ch_update   (ch_update),
        .ch_tdi      (ch_tdi),
        .ch_tdo      (ch_tdo),
        .dmi_req     (dmi_req),
        .dmi_wr      (dmi_wr),
        .dmi_addr    (dmi_addr),
        .dmi_wdata   (dmi_wdata),
        .dmi_resp    (dmi_resp),
        .dmi_rdata   (dmi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: the scan register contents, one outstanding transaction, the error flag
    bit [SW-1:0] m_scan;
    bit          m_busy;
    bit          m_sticky;
    bit          m_wr;
    bit [AW-1:0] m_addr;
    bit [DW-1:0] m_wdata;
    bit [DW-1:0] m_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_scan = '0; m_busy = 0; m_sticky = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit          hit;
        bit          busy0;
        bit [1:0]    op;
        bit [AW-1:0] a0;
        bit [DW-1:0] r0;
        hit   = ch_sel && (ch_id == CHW'(1));
        busy0 = m_busy;
        a0    = m_addr;
        r0    = m_rdata;
        if (m_busy && dmi_resp) begin
            m_busy = 0;
            if (!m_wr) m_rdata = dmi_rdata;
        end
        if (hit && ch_update) begin
            op = m_scan[1:0];
            if (busy0) begin
                if (op != 2'd0) m_sticky = 1;
            end else if (op == 2'd1 || op == 2'd2) begin
                m_busy = 1;
                m_wr   = (op == 2'd2);
                m_addr = m_scan[SW-1:SW-AW];
                if (op == 2'd2) m_wdata = m_scan[DW+1:2];
            end
        end else if (hit && ch_capture) begin
            m_scan = {a0, r0, ((busy0 || m_sticky) ? 2'b11 : 2'b00)};
        end else if (hit && ch_shift) begin
            m_scan = {ch_tdi, m_scan[SW-1:1]};
        end
    endtask

    task automatic tick(input bit chk = 1'b1);
        model_step();
        @(posedge clk);
        #1;
        if (chk)
            check("cycle_outputs", {22'd0, ch_tdo, dmi_req, dmi_wr, dmi_addr, dmi_wdata},
                  {22'd0, m_scan[0], m_busy, m_wr, m_addr, m_wdata});
    endtask

    task automatic drive_idle();
        ch_capture = 0; ch_shift = 0; ch_update = 0; ch_tdi = 0; dmi_resp = 0;
    endtask

    task automatic shift_in(input bit sel, input logic [CHW-1:0] id, input logic [SW-1:0] val);
        for (int i = 0; i < SW; i++) begin
            ch_sel = sel; ch_id = id; ch_shift = 1; ch_tdi = val[i];
            tick();
        end
        ch_shift = 0; ch_tdi = 0;
    endtask

    task automatic do_update();
        ch_update = 1;
        tick();
        ch_update = 0;
    endtask

    task automatic read_out(output logic [SW-1:0] v);
        ch_sel = 1; ch_id = CHW'(1);
        ch_capture = 1;
        tick();
        ch_capture = 0;
        v[0] = ch_tdo;
        for (int i = 1; i < SW; i++) begin
            ch_shift = 1; ch_tdi = 0;
            tick();
            v[i] = ch_tdo;
        end
        ch_shift = 0;
    endtask

    task automatic respond(input int dly, input logic [DW-1:0] rd);
        repeat (dly) tick();
        dmi_resp = 1; dmi_rdata = rd;
        tick();
        dmi_resp = 0;
    endtask

    typedef struct {
        bit           sel;
        bit [CHW-1:0] id;
        bit [1:0]     op;
        bit [AW-1:0]  addr;
        bit [DW-1:0]  data;
        bit [DW-1:0]  rdata;
        bit           exp_req;
        bit           exp_wr;
        bit [AW-1:0]  exp_addr;
        bit [DW-1:0]  exp_wdata;
        bit [AW-1:0]  exp_cap_addr;
        bit [DW-1:0]  exp_cap_data;
        bit [1:0]     exp_status;
    } vec_t;

    vec_t        vecs[8];
    logic [SW-1:0] cap;

    initial begin
        vecs[0] = '{1, CHW'(1), 2'd2, 7'h10, 32'hDEADBEEF, 32'h0,        1, 1, 7'h10, 32'hDEADBEEF, 7'h10, 32'h0,        2'd0};
        vecs[1] = '{1, CHW'(1), 2'd1, 7'h11, 32'h0,        32'h12345678, 1, 0, 7'h11, 32'hDEADBEEF, 7'h11, 32'h12345678, 2'd0};
        vecs[2] = '{0, CHW'(1), 2'd2, 7'h22, 32'hAAAA5555, 32'h0,        0, 0, 7'h11, 32'hDEADBEEF, 7'h11, 32'h12345678, 2'd0};
        vecs[3] = '{1, CHW'(0), 2'd1, 7'h33, 32'h0,        32'h0,        0, 0, 7'h11, 32'hDEADBEEF, 7'h11, 32'h12345678, 2'd0};
        vecs[4] = '{1, CHW'(1), 2'd3, 7'h44, 32'h1,        32'h0,        0, 0, 7'h11, 32'hDEADBEEF, 7'h11, 32'h12345678, 2'd0};
        vecs[5] = '{1, CHW'(1), 2'd0, 7'h55, 32'h77,       32'h0,        0, 0, 7'h11, 32'hDEADBEEF, 7'h11, 32'h12345678, 2'd0};
        vecs[6] = '{1, CHW'(1), 2'd2, 7'h7F, 32'hFFFFFFFF, 32'h0,        1, 1, 7'h7F, 32'hFFFFFFFF, 7'h7F, 32'h12345678, 2'd0};
        vecs[7] = '{1, CHW'(1), 2'd1, 7'h00, 32'h0,        32'hA5A5A5A5, 1, 0, 7'h00, 32'hFFFFFFFF, 7'h00, 32'hA5A5A5A5, 2'd0};

        // Reset state
        tapc_trst_n = 0; ch_sel = 0; ch_id = '0; dmi_rdata = '0;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {22'd0, ch_tdo, dmi_req, dmi_wr, dmi_addr, dmi_wdata}, 64'd0);
        tapc_trst_n = 1;
        tick();

        // Transaction table
        for (int k = 0; k < 8; k++) begin
            shift_in(vecs[k].sel, vecs[k].id, {vecs[k].addr, vecs[k].data, vecs[k].op});
            do_update();
            check($sformatf("vec%0d_req", k), {63'd0, dmi_req}, {63'd0, vecs[k].exp_req});
            if (vecs[k].exp_req) begin
                check($sformatf("vec%0d_reqfields", k), {24'd0, dmi_wr, dmi_addr, dmi_wdata},
                      {24'd0, vecs[k].exp_wr, vecs[k].exp_addr, vecs[k].exp_wdata});
                respond(5, vecs[k].rdata);
                check($sformatf("vec%0d_req_drop", k), {63'd0, dmi_req}, 64'd0);
            end
            read_out(cap);
            check($sformatf("vec%0d_capture", k), {23'd0, cap},
                  {23'd0, vecs[k].exp_cap_addr, vecs[k].exp_cap_data, vecs[k].exp_status});
        end

        // Busy update: no second request, sticky status 3, later requests still issue
        shift_in(1, CHW'(1), {7'h05, 32'h0, 2'd1});
        do_update();
        check("busy_first_req", {56'd0, dmi_req, dmi_addr}, {56'd0, 1'b1, 7'h05});
        shift_in(1, CHW'(1), {7'h06, 32'h0, 2'd1});
        do_update();
        check("busy_no_new_req", {55'd0, dmi_req, dmi_wr, dmi_addr}, {55'd0, 1'b1, 1'b0, 7'h05});
        respond(2, 32'hCAFEF00D);
        read_out(cap);
        check("busy_sticky_capture", {23'd0, cap}, {23'd0, 7'h05, 32'hCAFEF00D, 2'b11});
        shift_in(1, CHW'(1), {7'h09, 32'h0, 2'd1});
        do_update();
        check("sticky_not_blocking", {56'd0, dmi_req, dmi_addr}, {56'd0, 1'b1, 7'h09});
        respond(1, 32'h11112222);
        read_out(cap);
        check("sticky_persists", {23'd0, cap}, {23'd0, 7'h09, 32'h11112222, 2'b11});

        // Asynchronous reset in the middle of a request
        shift_in(1, CHW'(1), {7'h0C, 32'h0, 2'd1});
        do_update();
        check("pre_reset_req", {63'd0, dmi_req}, 64'd1);
        #2 tapc_trst_n = 0;
        #1;
        check("reset_req_drop_async", {22'd0, ch_tdo, dmi_req, dmi_wr, dmi_addr, dmi_wdata}, 64'd0);
        model_reset();
        @(posedge clk);
        #2 tapc_trst_n = 1;
        dmi_resp = 1; dmi_rdata = 32'hFFFFFFFF;
        tick();
        dmi_resp = 0;
        check("late_resp_ignored", {63'd0, dmi_req}, 64'd0);
        read_out(cap);
        check("post_reset_capture", {23'd0, cap}, 64'd0);

        // Update and capture together: update wins; response in first req cycle accepted
        shift_in(1, CHW'(1), {7'h12, 32'h55, 2'd1});
        ch_update = 1; ch_capture = 1;
        tick();
        ch_update = 0; ch_capture = 0;
        check("upd_beats_capture", {62'd0, dmi_req, ch_tdo}, {62'd0, 1'b1, 1'b1});
        dmi_resp = 1; dmi_rdata = 32'h0BADCAFE;
        tick();
        dmi_resp = 0;
        check("immediate_resp", {63'd0, dmi_req}, 64'd0);
        read_out(cap);
        check("immediate_resp_capture", {23'd0, cap}, {23'd0, 7'h12, 32'h0BADCAFE, 2'b00});

`ifdef SCR1_DMI_DTMCS_EN
        // DTMCS: fixed fields, dmistat after busy error, dmireset clears it
        begin
            logic [31:0] dt;
            shift_in(1, CHW'(1), {7'h01, 32'h0, 2'd1});
            do_update();
            do_update();
            respond(1, 32'h0);
            ch_sel = 1; ch_id = CHW'(0); ch_capture = 1;
            tick(1'b0);
            ch_capture = 0;
            dt[0] = ch_tdo;
            for (int i = 1; i < 32; i++) begin
                ch_shift = 1; ch_tdi = 0;
                tick(1'b0);
                dt[i] = ch_tdo;
            end
            ch_shift = 0;
            check("dtmcs_fields", {52'd0, dt[11:0]}, {52'd0, 2'b11, 6'd7, 4'd1});
            for (int i = 0; i < 32; i++) begin
                ch_shift = 1; ch_tdi = (i == 16);
                tick(1'b0);
            end
            ch_shift = 0; ch_tdi = 0;
            ch_update = 1;
            tick(1'b0);
            ch_update = 0;
            m_sticky = 0;
            read_out(cap);
            check("dmireset_status", {62'd0, cap[1:0]}, 64'd0);
        end
`endif

        // Randomized phase against the model
        for (int n = 0; n < 3000; n++) begin
            ch_sel     = ($urandom_range(0, 3) != 0);
`ifdef SCR1_DMI_DTMCS_EN
            ch_id      = CHW'($urandom_range(1, 3));
`else
            ch_id      = CHW'($urandom_range(0, 3));
`endif
            ch_capture = ($urandom_range(0, 9) < 2);
            ch_shift   = ($urandom_range(0, 9) < 5);
            ch_update  = ($urandom_range(0, 9) < 1);
            ch_tdi     = ($urandom_range(0, 1) != 0);
            dmi_resp   = ($urandom_range(0, 9) < 2);
            dmi_rdata  = $urandom;
            tick();
        end
        drive_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scr1_dmi_scan_responder.md
Name: scr1_dmi_scan_responder

Overview:
SysCLK-domain responder at the core end of the TAPC DMI scan chain. It consumes the single-cycle capture/shift/update/TDI strobes produced by the TAPC clock-domain synchronizer and implements the 41-bit DMI scan register. On update it issues read/write requests to the Debug Module over a req/resp handshake, and drives the chain TDO bit back toward the TCK domain.

Parameters:
ADDR_W, 7, DMI address width.
DATA_W, 32, DMI data width; scan register width = ADDR_W+DATA_W+2.
DMI_CH_ID, 1, ch_id value selecting the DMI register.
DTMCS_CH_ID, 0, ch_id value selecting DTMCS (used only with the optional feature).

Ports:
clk  in  1  system clock (SysCLK)
tapc_trst_n  in  1  async active-low reset
ch_sel  in  1  DMI chain selected (level, SysCLK domain)
ch_id  in  SCR1_DBG_DMI_CH_ID_WIDTH  chain identifier
ch_capture  in  1  capture strobe, 1 clk
ch_shift  in  1  shift strobe, 1 clk
ch_update  in  1  update strobe, 1 clk
ch_tdi  in  1  TDI bit, valid with ch_shift
ch_tdo  out  1  TDO bit = scan register bit 0
dmi_req  out  1  request valid to DM
dmi_wr  out  1  1 = write, 0 = read
dmi_addr  out  ADDR_W  request address
dmi_wdata  out  DATA_W  write data
dmi_resp  in  1  DM response strobe, 1 clk
dmi_rdata  in  DATA_W  read data, valid with dmi_resp

Behaviour:
- Reset (tapc_trst_n=0, async): scan register 0, ch_tdo 0, dmi_req 0, dmi_wr 0, dmi_addr 0, dmi_wdata 0, rdata_q 0, status 0, FSM=IDLE.
- Strobes act only when ch_sel=1 and ch_id==DMI_CH_ID; otherwise ignored. Strobe priority when simultaneous: update > capture > shift.
- Scan register layout, LSB first: op[1:0], data[DATA_W+1:2], addr[top].
- Capture: load {addr_q, rdata_q, status}. status is 3 while busy or when the sticky error is set; otherwise the last completed status: 0 = ok.
- Shift: reg <= {ch_tdi, reg[W-1:1]}. ch_tdo always equals reg[0] (registered).
- Update: decode op. Op 0 = nop; op 3 = reserved, treated as nop. If FSM != IDLE and op != 0, set the sticky error and issue no request. Op 1 = read: latch addr, assert dmi_req with dmi_wr=0, FSM=REQ. Op 2 = write: latch addr and data, assert dmi_req with dmi_wr=1, FSM=REQ.
- FSM IDLE -> REQ: on a valid update.
- FSM REQ: dmi_req held high and addr/wdata/wr held stable. On dmi_resp: drop dmi_req the next cycle, load rdata_q <= dmi_rdata for reads (retain for writes), go to IDLE. dmi_resp in the same cycle as req assertion is accepted.
- dmi_resp while IDLE: ignored.
- Sticky error: set only by a busy update; cleared only by reset, or by dmireset under the optional feature. It never blocks new requests. Busy is evaluated before the FSM transition in the same cycle.
- Reset mid-request: dmi_req drops asynchronously; any later dmi_resp is ignored.
- Latency: update to dmi_req high is 1 clk; dmi_resp to IDLE and capture-ready is 1 clk.

Optional Feature:
SCR1_DMI_DTMCS_EN.
- Defined: ch_id==DTMCS_CH_ID selects a 32-bit DTMCS shift register. Capture loads {version=1 [3:0], abits=ADDR_W [9:4], dmistat [11:10], idle=0}; dmistat = 3 if sticky error, else 0. Shift behaves as for DMI. Update with bit16 (dmireset) clears the sticky error. Update with bit17 (dmihardreset) also forces FSM=IDLE and dmi_req=0, abandoning the transaction.
- Undefined: DTMCS_CH_ID is unused and no DTMCS register exists. The sticky error clears only on reset.

Test Plan:
- Reset: assert tapc_trst_n=0 mid-REQ -> dmi_req=0 immediately; later capture yields all-zero register.
- Write: shift 41 bits {addr=0x10, data=0xDEADBEEF, op=2}, then update -> next clk dmi_req=1, dmi_wr=1, addr=0x10, wdata=0xDEADBEEF held until dmi_resp; then IDLE.
- Read: op=1, addr=0x11; DM returns dmi_rdata=0x12345678 after 5 clk; then capture plus 41 shifts -> TDO stream shows data 0x12345678, status 0.
- Busy: second update op=1 while REQ -> no new request; capture shows status 3 even after response.
- Deselect: strobes with ch_sel=0 or ch_id!=DMI_CH_ID -> register and dmi_req unchanged; same-cycle update+capture -> update wins.
- SCR1_DMI_DTMCS_EN: DTMCS capture -> abits=7, version=1, dmistat=3 after busy; update with bit16=1 -> next DMI capture status 0.
